// File: rtl/dallanma_denetleyici_pkg.sv
// Shared types and default constants for the branch resolution sequencer.
package dallanma_denetleyici_pkg;

   typedef enum logic {
      BOSTA  = 1'b0,
      BOSALT = 1'b1
   } durum_e;

   localparam int VARSAYILAN_DERINLIK = 4;
   localparam int VARSAYILAN_BOSALTMA = 2;
   localparam int VARSAYILAN_PS       = 32;

   function automatic int sayac_genislik(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dallanma_denetleyici_kuyruk.sv
// Predictor-update FIFO: synchronous, wrap-bit pointers, zero-latency head.
module dal_guncelle_kuyrugu
   import dallanma_denetleyici_pkg::*;
#(
   parameter int DERINLIK      = VARSAYILAN_DERINLIK,
   parameter int VERI_GENISLIK = 2 * VARSAYILAN_PS + 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [VERI_GENISLIK-1:0] veri_i,
   input  logic                     pop_i,
   output logic                     dolu_o,
   output logic                     bos_o,
   output logic [VERI_GENISLIK-1:0] bas_o
);

   localparam int AW = $clog2(DERINLIK);

   logic [AW:0]              yaz_q, yaz_d;
   logic [AW:0]              oku_q, oku_d;
   logic [VERI_GENISLIK-1:0] bellek_q [DERINLIK];
   logic                     yaz_ok;
   logic                     oku_ok;

   assign bos_o  = (yaz_q == oku_q);
   assign dolu_o = (yaz_q[AW] != oku_q[AW]) &&
                   (yaz_q[AW-1:0] == oku_q[AW-1:0]);

   // A push into a full queue is only kept when a pop frees the slot.
   assign yaz_ok = push_i && (!dolu_o || pop_i);
   assign oku_ok = pop_i && !bos_o;
   assign bas_o  = bellek_q[oku_q[AW-1:0]];

   always_comb begin
      yaz_d = yaz_q;
      oku_d = oku_q;
      if (yaz_ok) yaz_d = yaz_q + 1'b1;
      if (oku_ok) oku_d = oku_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         yaz_q <= '0;
         oku_q <= '0;
      end else begin
         yaz_q <= yaz_d;
         oku_q <= oku_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (yaz_ok) bellek_q[yaz_q[AW-1:0]] <= veri_i;
   end

endmodule

// File: rtl/dallanma_denetleyici.sv
// Branch resolution sequencer: redirect, flush window, predictor-update FIFO.
// Optional DAL_SAYAC_EN adds saturating branch/mispredict counters.
module dallanma_denetleyici
   import dallanma_denetleyici_pkg::*;
#(
   parameter int KUYRUK_DERINLIK = VARSAYILAN_DERINLIK,
   parameter int BOSALTMA_CEVRIM = VARSAYILAN_BOSALTMA,
   parameter int PS_GENISLIK     = VARSAYILAN_PS
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   guncelle_gecerli_i,
   input  logic                   guncelle_atladi_i,
   input  logic                   dallanma_hata_i,
   input  logic [PS_GENISLIK-1:0] guncelle_ps_i,
   input  logic [PS_GENISLIK-1:0] guncelle_hedef_adresi_i,
   output logic                   yonlendir_gecerli_o,
   output logic [PS_GENISLIK-1:0] yonlendir_ps_o,
   output logic                   bosalt_o,
   output logic                   durdur_o,
   output logic                   ongorucu_gecerli_o,
   input  logic                   ongorucu_hazir_i,
   output logic [PS_GENISLIK-1:0] ongorucu_ps_o,
   output logic                   ongorucu_atladi_o,
   output logic [PS_GENISLIK-1:0] ongorucu_hedef_o,
   output logic                   tasma_o
`ifdef DAL_SAYAC_EN
   ,
   output logic [31:0]            dal_sayisi_o,
   output logic [31:0]            hata_sayisi_o
`endif
);

   localparam int SW = sayac_genislik(BOSALTMA_CEVRIM);
   localparam int VW = 2 * PS_GENISLIK + 1;

   durum_e                 durum_q, durum_d;
   logic [SW-1:0]          sayac_q, sayac_d;
   logic                   yon_gecerli_q, yon_gecerli_d;
   logic [PS_GENISLIK-1:0] yon_ps_q, yon_ps_d;
   logic                   tasma_q, tasma_d;

   logic                   kabul;
   logic                   cek;
   logic                   dolu;
   logic                   bos;
   logic [VW-1:0]          bas;

   // Inputs seen during the flush belong to wrong-path instructions.
   assign kabul = guncelle_gecerli_i && (durum_q == BOSTA);
   assign cek   = !bos && ongorucu_hazir_i;

   dal_guncelle_kuyrugu #(
      .DERINLIK      (KUYRUK_DERINLIK),
      .VERI_GENISLIK (VW)
   ) u_kuyruk (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .push_i (kabul),
      .veri_i ({guncelle_ps_i, guncelle_atladi_i,
                guncelle_hedef_adresi_i}),
      .pop_i  (cek),
      .dolu_o (dolu),
      .bos_o  (bos),
      .bas_o  (bas)
   );

   always_comb begin
      durum_d       = durum_q;
      sayac_d       = sayac_q;
      yon_gecerli_d = 1'b0;
      yon_ps_d      = yon_ps_q;
      tasma_d       = tasma_q | (kabul && dolu && !cek);
      unique case (durum_q)
         BOSTA: begin
            if (kabul && dallanma_hata_i) begin
               durum_d       = BOSALT;
               sayac_d       = SW'(BOSALTMA_CEVRIM - 1);
               yon_gecerli_d = 1'b1;
               yon_ps_d      = guncelle_hedef_adresi_i;
            end
         end
         BOSALT: begin
            if (sayac_q == '0) durum_d = BOSTA;
            else               sayac_d = sayac_q - 1'b1;
         end
         default: durum_d = BOSTA;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         durum_q       <= BOSTA;
         sayac_q       <= '0;
         yon_gecerli_q <= 1'b0;
         yon_ps_q      <= '0;
         tasma_q       <= 1'b0;
      end else begin
         durum_q       <= durum_d;
         sayac_q       <= sayac_d;
         yon_gecerli_q <= yon_gecerli_d;
         yon_ps_q      <= yon_ps_d;
         tasma_q       <= tasma_d;
      end
   end

   assign yonlendir_gecerli_o = yon_gecerli_q;
   assign yonlendir_ps_o      = yon_ps_q;
   assign bosalt_o            = (durum_q == BOSALT);
   assign durdur_o            = dolu || (durum_q == BOSALT);
   assign tasma_o             = tasma_q;

   // Head is masked while empty so stale storage never leaks out.
   assign ongorucu_gecerli_o = !bos;
   assign ongorucu_ps_o      = bos ? '0 : bas[VW-1 -: PS_GENISLIK];
   assign ongorucu_atladi_o  = bos ? 1'b0 : bas[PS_GENISLIK];
   assign ongorucu_hedef_o   = bos ? '0 : bas[PS_GENISLIK-1:0];

`ifdef DAL_SAYAC_EN
   logic [31:0] dal_q, dal_d;
   logic [31:0] hata_q, hata_d;

   always_comb begin
      dal_d  = dal_q;
      hata_d = hata_q;
      if (kabul && dal_q != 32'hFFFF_FFFF)
         dal_d = dal_q + 32'd1;
      if (kabul && dallanma_hata_i && hata_q != 32'hFFFF_FFFF)
         hata_d = hata_q + 32'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dal_q  <= '0;
         hata_q <= '0;
      end else begin
         dal_q  <= dal_d;
         hata_q <= hata_d;
      end
   end

   assign dal_sayisi_o  = dal_q;
   assign hata_sayisi_o = hata_q;
`endif

endmodule

// File: doc/dallanma_denetleyici.md
Name: dallanma_denetleyici

Overview:
- Sequences the pipeline response to resolved branches from the execute-stage branch unit.
- On a misprediction it issues a one-cycle PC redirect, then holds a fetch/decode flush for a fixed number of cycles.
- Every valid branch resolution goes into a small FIFO, which drains to the branch predictor's single update port through a valid/ready handshake.
- Sits between the branch unit outputs, the fetch stage (PC mux, flush) and the predictor table.

Parameters:
- KUYRUK_DERINLIK, 4: predictor-update FIFO depth; power of two, ≥2.
- BOSALTMA_CEVRIM, 2: cycles bosalt_o stays high after a mispredict; ≥1.
- PS_GENISLIK, 32: PC/address width.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous active-high reset.
- guncelle_gecerli_i  input  1  branch unit: a branch resolved this cycle.
- guncelle_atladi_i  input  1  resolved branch was taken.
- dallanma_hata_i  input  1  prediction was wrong.
- guncelle_ps_i  input  PS_GENISLIK  PC of the branch.
- guncelle_hedef_adresi_i  input  PS_GENISLIK  correct next PC.
- yonlendir_gecerli_o  output  1  fetch must load yonlendir_ps_o this cycle.
- yonlendir_ps_o  output  PS_GENISLIK  redirect PC.
- bosalt_o  output  1  squash fetch/decode contents.
- durdur_o  output  1  stall the execute branch path; high while the FIFO is full or the block is in BOSALT.
- ongorucu_gecerli_o  output  1  update available at the FIFO head.
- ongorucu_hazir_i  input  1  predictor accepts an update.
- ongorucu_ps_o  output  PS_GENISLIK  head entry PC.
- ongorucu_atladi_o  output  1  head entry taken flag.
- ongorucu_hedef_o  output  PS_GENISLIK  head entry target.
- tasma_o  output  1  sticky: an update arrived while the FIFO was full and was dropped.

Behaviour:
- Reset: synchronous, active-high, sampled on the clk_i rising edge.
  - All outputs return to 0.
  - FIFO empties, FSM goes to BOSTA, flush counter clears.
  - Reset mid-flush or with a non-empty FIFO discards everything.
- FSM states: BOSTA and BOSALT.
  - BOSTA -> BOSALT: guncelle_gecerli_i && dallanma_hata_i sampled at edge N.
  - On entry, the flush counter loads BOSALTMA_CEVRIM-1.
  - yonlendir_gecerli_o=1 and yonlendir_ps_o=guncelle_hedef_adresi_i are registered outputs, valid in cycle N+1 only.
  - bosalt_o=1 for cycles N+1 .. N+BOSALTMA_CEVRIM.
  - BOSALT -> BOSTA when the counter is 0 at an edge; otherwise the counter decrements.
  - yonlendir_ps_o holds its last value when not valid.
- In BOSALT, all branch-unit inputs are ignored. They belong to wrong-path instructions: no enqueue, no new redirect.
- Enqueue: in BOSTA, every guncelle_gecerli_i=1 pushes {ps, atladi, hedef}. This includes the mispredicting branch itself.
- Dequeue: occurs on ongorucu_gecerli_o && ongorucu_hazir_i.
  - ongorucu_gecerli_o = !empty.
  - Head outputs come straight from the FIFO storage (no extra latency).
  - An entry pushed at edge N is visible at the head in cycle N+1 if the FIFO was empty.
- Simultaneous push and pop when full: allowed. Occupancy stays constant and nothing is dropped.
- Push when full without a pop: entry dropped, tasma_o set until reset. Normally prevented, since durdur_o = full || (state==BOSALT).
- Pointers: log2(KUYRUK_DERINLIK) bits plus one wrap bit.
  - full when indices are equal and wrap bits differ; empty when both are equal.
  - Pointers wrap modulo depth.
- Ready without valid: no effect.

Optional Feature:
- Macro: DAL_SAYAC_EN.
- With DAL_SAYAC_EN defined:
  - Adds outputs dal_sayisi_o[31:0] and hata_sayisi_o[31:0].
  - Each counts branches accepted in BOSTA and mispredicts accepted in BOSTA, respectively.
  - Both saturate at 32'hFFFFFFFF and clear on rst_i.
- Without it: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package/header (the operations header): FSM state encodings and the default constants for depth and flush length.
- One natural sub-module: dal_guncelle_kuyrugu.
  - Parameterised synchronous FIFO carrying {ps, atladi, hedef}.
  - Ports push/pop/full/empty/head.
- The top level holds the FSM, redirect register and flush counter.

Test Plan:
- Mispredict: mispredict at 0x0000_0100 with target 0x0000_0200 in BOSTA.
  - yonlendir_gecerli_o=1 with PS 0x200 for exactly one cycle.
  - bosalt_o high for 2 cycles.
  - One FIFO entry {0x100, atladi, 0x200}.
- Wrong-path suppression: second mispredict one cycle into BOSALT -> ignored, no second redirect, FIFO count unchanged.
- Fill and drain:
  - Hold ongorucu_hazir_i=0 and push 4 correct branches -> durdur_o=1 once full.
  - Force a 5th push -> tasma_o=1.
  - Release ready -> 4 entries drain in order, one per cycle.
- Full-FIFO push with pop: FIFO full, simultaneous push and pop -> no drop, tasma_o stays 0, order preserved across pointer wrap.
- Reset mid-flush: rst_i high during BOSALT with 3 FIFO entries -> next cycle all outputs 0, FIFO empty, BOSTA.
- Counters: with DAL_SAYAC_EN, 10 branches with 3 mispredicts spaced beyond the flush window -> dal_sayisi_o=10, hata_sayisi_o=3.
